// File: rtl/tx_sched_pkg.sv
// Shared constants for the transmit frame scheduler: FSM encoding, default sizing, clog2 helper.
package tx_sched_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] SEND = 2'd2;
  localparam logic [1:0] GAP  = 2'd3;

  localparam int DEF_N_REQ      = 4;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_TIMEOUT    = 31;
  localparam int DEF_GAP_CYCLES = 2;

  // Never returns less than 1 so single-entry indices still get a real bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/tx_frame_scheduler_if.sv
// Producer + transmitter pins of the scheduler; slave = scheduler view, master = environment view.
interface tx_frame_scheduler_if import tx_sched_pkg::*; #(
  parameter int N_REQ  = DEF_N_REQ,
  parameter int DATA_W = DEF_DATA_W
) ();
  localparam int ID_W = clog2(N_REQ);

  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        grant;
  logic [N_REQ-1:0]        ack;
  logic                    err;
  logic                    busy;
  logic [ID_W-1:0]         cur_id;
  logic                    tx_start;
  logic [DATA_W-1:0]       tx_data;
  logic                    tx_done;

  modport master (
    output req, req_data, tx_done,
    input  grant, ack, err, busy, cur_id, tx_start, tx_data
  );

  modport slave (
    input  req, req_data, tx_done,
    output grant, ack, err, busy, cur_id, tx_start, tx_data
  );
endinterface

// File: rtl/tx_frame_scheduler_rr_pick.sv
// Combinational round-robin picker: first asserted req searching upward from ptr, wrapping mod N_REQ.
module rr_pick import tx_sched_pkg::*; #(
  parameter int N_REQ = DEF_N_REQ,
  parameter int ID_W  = clog2(DEF_N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [ID_W-1:0]  idx_o,
  output logic             vld_o
);
  logic [ID_W-1:0] j;

  // Walk from the farthest offset back toward ptr so the nearest hit is written last.
  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    j     = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = ID_W'((int'(ptr_i) + i) % N_REQ);
      if (req_i[j]) begin
        idx_o = j;
        vld_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/tx_frame_scheduler.sv
// Shares one serial transmitter among N_REQ producers: round-robin grant, LOAD/SEND/GAP sequencing.
// Grant one cycle after req seen in IDLE, tx_start one cycle later; producers hold req until ack.
module tx_frame_scheduler import tx_sched_pkg::*; #(
  parameter int N_REQ      = DEF_N_REQ,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input logic                 clock,
  input logic                 reset,
  tx_frame_scheduler_if.slave bus
);
  localparam int ID_W  = clog2(N_REQ);
  localparam int CNT_W = clog2(TIMEOUT + GAP_CYCLES + 1);

  logic [1:0]        state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic [ID_W-1:0]   cur_id_q, cur_id_d;
  logic              tx_start_q, tx_start_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;

  logic [ID_W-1:0]   winner;
  logic              win_vld;
  logic [DATA_W-1:0] req_bytes [N_REQ];

  always_comb begin
    for (int i = 0; i < N_REQ; i++) req_bytes[i] = bus.req_data[i*DATA_W +: DATA_W];
  end

  rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
    .req_i (bus.req),
    .ptr_i (ptr_q),
    .idx_o (winner),
    .vld_o (win_vld)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      grant_q    <= '0;
      ack_q      <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      cur_id_q   <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      cur_id_q   <= cur_id_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // A done arriving on the final counted cycle still wins over the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_vld) state_d = LOAD;
      LOAD:    state_d = SEND;
      SEND:    if (bus.tx_done || cnt_q == CNT_W'(TIMEOUT)) state_d = GAP;
      GAP:     if (cnt_q == CNT_W'(GAP_CYCLES - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from the next state so every port comes straight off a flop.
  always_comb begin
    ptr_d     = ptr_q;
    cur_id_d  = cur_id_q;
    tx_data_d = tx_data_q;
    if (state_q == IDLE && win_vld) begin
      cur_id_d  = winner;
      tx_data_d = req_bytes[winner];
      ptr_d     = (int'(winner) == N_REQ - 1) ? '0 : winner + ID_W'(1);
    end
    cnt_d = '0;
    if ((state_q == SEND || state_q == GAP) && state_d == state_q) cnt_d = cnt_q + CNT_W'(1);
    grant_d    = (state_d == LOAD || state_d == SEND) ? (N_REQ'(1) << cur_id_d) : '0;
    ack_d      = (state_q == SEND && bus.tx_done) ? (N_REQ'(1) << cur_id_q) : '0;
    err_d      = (state_q == SEND) && !bus.tx_done && (cnt_q == CNT_W'(TIMEOUT));
    busy_d     = (state_d != IDLE);
    tx_start_d = (state_d == SEND);
  end

  assign bus.grant    = grant_q;
  assign bus.ack      = ack_q;
  assign bus.err      = err_q;
  assign bus.busy     = busy_q;
  assign bus.cur_id   = cur_id_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Bench for tx_frame_scheduler: cycle-timeline model checked every cycle plus directed literal checks.
module tb_tx_frame_scheduler;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 31;
  localparam int GC = 2;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  tx_frame_scheduler_if #(.N_REQ(N), .DATA_W(DW)) bus ();

  tx_frame_scheduler #(.N_REQ(N), .DATA_W(DW), .TIMEOUT(TO), .GAP_CYCLES(GC)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int done_k = 0;

  // recorder state
  int          q_ids [$];
  logic [7:0]  q_dat [$];
  int          ack_cnt = 0;
  int          err_cnt = 0;
  int          send_len = 0;
  int          st_run = 0;
  logic [N-1:0] last_ack = '0;
  logic [N-1:0] prev_grant = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Frame timeline model: a frame is granted at cycle tg, transmits from tg+1,
  // ends at te (ack or err on te), and the scheduler is idle again at te+GC.
  initial begin
    bit           en, active, ok, idle, live, open;
    int           tg, te, owner, ptr, j;
    logic [7:0]   data;
    logic [N-1:0] oh;
    en = 0; active = 0; ok = 0; tg = 0; te = -1; owner = 0; ptr = 0; data = 0;
    forever begin
      @(negedge clock);
      cyc++;
      if (en) begin
        oh   = N'(1) << owner;
        live = active && cyc >= tg;
        open = (te < 0) || (cyc < te);
        chk("grant",    32'(bus.grant),    (live && open) ? 32'(oh) : 32'd0);
        chk("tx_start", 32'(bus.tx_start), 32'(active && cyc >= tg + 1 && open));
        chk("ack",      32'(bus.ack),      (active && te == cyc && ok) ? 32'(oh) : 32'd0);
        chk("err",      32'(bus.err),      32'(active && te == cyc && !ok));
        chk("busy",     32'(bus.busy),     32'(live && (te < 0 || cyc < te + GC)));
        chk("cur_id",   32'(bus.cur_id),   32'(owner));
        chk("tx_data",  32'(bus.tx_data),  32'(data));
      end
      if (bus.grant != 0 && prev_grant == 0) begin
        q_ids.push_back(int'(bus.cur_id));
        q_dat.push_back(bus.tx_data);
      end
      prev_grant = bus.grant;
      if (bus.ack != 0) begin ack_cnt++; last_ack = bus.ack; end
      if (bus.err) err_cnt++;
      if (bus.tx_start) st_run++;
      else if (st_run != 0) begin send_len = st_run; st_run = 0; end
      // advance model to cycle cyc+1 using inputs sampled at the coming edge
      if (reset) begin
        en = 1; active = 0; ptr = 0; owner = 0; data = 0; te = -1;
      end else if (en) begin
        idle = !active || (te >= 0 && cyc >= te + GC);
        if (idle) begin
          active = 0;
          for (int i = 0; i < N; i++) begin
            j = (ptr + i) % N;
            if (!active && bus.req[j]) begin
              active = 1; owner = j; data = bus.req_data[j*DW +: DW];
              ptr = (j + 1) % N; tg = cyc + 1; te = -1;
            end
          end
        end else if (te < 0 && cyc >= tg + 1) begin
          if (bus.tx_done) begin te = cyc + 1; ok = 1; end
          else if (cyc - (tg + 1) == TO) begin te = cyc + 1; ok = 0; end
        end
      end
    end
  end

  // Transmitter responder: pulses tx_done on the done_k-th cycle of tx_start high (0 = never).
  initial begin
    int scnt;
    scnt = 0;
    bus.tx_done = 1'b0;
    forever begin
      @(posedge clock); #1;
      if (bus.tx_start) scnt++; else scnt = 0;
      bus.tx_done = (done_k != 0) && bus.tx_start && (scnt == done_k);
    end
  end

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; step(); step(); reset = 1'b0;
  endtask

  task automatic wait_grants(input int n);
    int k;
    k = 0;
    while (q_ids.size() < n && k < 400) begin step(); k++; end
    if (q_ids.size() < n) begin
      checks++; errors++;
      $display("FAIL wait_grants: got %0d grants expected %0d", q_ids.size(), n);
    end
  endtask

  task automatic wait_idle();
    int k, quiet;
    k = 0; quiet = 0;
    while (quiet < 3 && k < 400) begin
      step(); k++;
      if (!bus.busy) quiet++; else quiet = 0;
    end
    if (quiet < 3) begin
      checks++; errors++;
      $display("FAIL wait_idle: busy still %0b expected 0", bus.busy);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, a0, e0;
    int exp_c [4];
    logic [7:0] dat_c [4];
    exp_c = '{0, 1, 3, 0};
    dat_c = '{8'h11, 8'h22, 8'h44, 8'h11};
    reset = 1'b1; bus.req = '0; bus.req_data = '0;
    step(); step(); step();
    reset = 1'b0;
    chk("reset_busy",  32'(bus.busy),  32'd0);
    chk("reset_grant", 32'(bus.grant), 32'd0);

    // single frame
    b = q_ids.size(); a0 = ack_cnt; e0 = err_cnt;
    bus.req_data = {8'h00, 8'hA5, 8'h00, 8'h00};
    bus.req = 4'b0100; done_k = 10;
    wait_grants(b + 1); bus.req = '0; wait_idle();
    chk("single_id",      32'(q_ids[b]), 32'd2);
    chk("single_data",    32'(q_dat[b]), 32'hA5);
    chk("single_sendlen", 32'(send_len), 32'd10);
    chk("single_ack",     32'(ack_cnt - a0), 32'd1);
    chk("single_ackvec",  32'(last_ack), 32'b0100);
    chk("single_err",     32'(err_cnt - e0), 32'd0);

    // contention
    do_reset();
    b = q_ids.size();
    bus.req_data = {8'h44, 8'h00, 8'h22, 8'h11};
    bus.req = 4'b1011; done_k = 3;
    wait_grants(b + 4); bus.req = '0; wait_idle();
    for (int i = 0; i < 4; i++) begin
      chk("cont_id",   32'(q_ids[b+i]), 32'(exp_c[i]));
      chk("cont_data", 32'(q_dat[b+i]), 32'(dat_c[i]));
    end

    // fairness
    do_reset();
    b = q_ids.size();
    bus.req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    bus.req = 4'b1111; done_k = 2;
    wait_grants(b + 8); bus.req = '0; wait_idle();
    for (int i = 0; i < 8; i++) chk("fair_id", 32'(q_ids[b+i]), 32'(i % 4));

    // timeout
    do_reset();
    b = q_ids.size(); a0 = ack_cnt; e0 = err_cnt;
    bus.req = 4'b0010; done_k = 0;
    wait_grants(b + 1); bus.req = '0; wait_idle();
    chk("to_id",      32'(q_ids[b]), 32'd1);
    chk("to_err",     32'(err_cnt - e0), 32'd1);
    chk("to_ack",     32'(ack_cnt - a0), 32'd0);
    chk("to_sendlen", 32'(send_len), 32'(TO + 1));

    // done exactly at the timeout count
    do_reset();
    a0 = ack_cnt; e0 = err_cnt;
    bus.req = 4'b0001; done_k = TO + 1;
    wait_grants(q_ids.size() + 1); bus.req = '0; wait_idle();
    chk("bnd_ack",     32'(ack_cnt - a0), 32'd1);
    chk("bnd_err",     32'(err_cnt - e0), 32'd0);
    chk("bnd_sendlen", 32'(send_len), 32'(TO + 1));

    // reset mid-frame
    do_reset();
    b = q_ids.size(); a0 = ack_cnt; e0 = err_cnt;
    bus.req_data = {8'h44, 8'h00, 8'h22, 8'h11};
    bus.req = 4'b1011; done_k = 3;
    wait_grants(b + 2); done_k = 0;
    repeat (5) step();
    reset = 1'b1; step(); reset = 1'b0;
    chk("rst_busy",     32'(bus.busy),     32'd0);
    chk("rst_grant",    32'(bus.grant),    32'd0);
    chk("rst_tx_start", 32'(bus.tx_start), 32'd0);
    chk("rst_cur_id",   32'(bus.cur_id),   32'd0);
    chk("rst_tx_data",  32'(bus.tx_data),  32'd0);
    done_k = 3;
    wait_grants(b + 3); bus.req = '0; wait_idle();
    chk("rst_id0",  32'(q_ids[b]),   32'd0);
    chk("rst_id1",  32'(q_ids[b+1]), 32'd1);
    chk("rst_next", 32'(q_ids[b+2]), 32'd0);
    chk("rst_ack",  32'(ack_cnt - a0), 32'd2);
    chk("rst_err",  32'(err_cnt - e0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tx_frame_scheduler.md
Name: tx_frame_scheduler

Overview:
- Shares one serial parity transmitter (8-bit load, level-held start, done pulse) among N_REQ byte producers.
- Arbitrates round-robin, latches the winner's byte and sequences the transmitter: load phase, then hold start until done, then an idle gap.
- Returns a per-requester ack, and an error pulse if the transmitter never reports done.
- Sits between the producer logic and the transmitter's start/data_in/tx_done pins.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width per requester.
- TIMEOUT, 31, maximum cycles in SEND before abort (≥8).
- GAP_CYCLES, 2, cycles start is held low between frames (≥1).

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-requester frame request; held until ack.
- req_data  in  N_REQ*DATA_W  requester i's byte in bits [i*DATA_W +: DATA_W].
- grant  out  N_REQ  one-hot; current owner during LOAD/SEND, else 0.
- ack  out  N_REQ  one-cycle pulse to the owner on successful completion.
- err  out  1  one-cycle pulse on timeout abort.
- busy  out  1  high in any state except IDLE.
- cur_id  out  clog2(N_REQ)  index of the last granted requester.
- tx_start  out  1  transmitter start; low = load/reset phase, high = shifting.
- tx_data  out  DATA_W  latched byte driven to the transmitter.
- tx_done  in  1  transmitter completion pulse.

Behaviour:
- All outputs are registered.
- Reset values: state IDLE; grant=0, ack=0, err=0, busy=0, cur_id=0, tx_start=0, tx_data=0; rr pointer=0; counters=0. Reset applies in any state and aborts any frame with no ack/err.
- States: IDLE, LOAD, SEND, GAP.
- IDLE:
  - If any req is high, pick the first asserted index searching from ptr upward, mod N_REQ.
  - Next cycle: LOAD, grant one-hot, cur_id=winner, tx_data=req_data[winner], ptr=winner+1 mod N_REQ.
  - If no req is high, stay in IDLE and leave ptr unchanged.
- LOAD: exactly 1 cycle with tx_start=0 and tx_data stable, then SEND.
- SEND:
  - tx_start=1; cycle counter starts at 0 on entry.
  - tx_done high goes to GAP with ack[owner] pulsed on the GAP-entry cycle.
  - Otherwise, if counter==TIMEOUT, go to GAP with err pulsed and no ack.
  - tx_done together with counter==TIMEOUT counts as success (ack, no err).
- GAP:
  - tx_start=0, grant=0; stay for GAP_CYCLES cycles, then IDLE.
  - The IDLE cycle may arbitrate immediately.
- Latency: req sampled high at IDLE cycle t; grant and LOAD at t+1; tx_start rises at t+2.
- tx_data is captured only at grant. Later changes to req_data or req do not affect the frame. Dropping req mid-frame does not abort.
- tx_done outside SEND is ignored.
- A requester holding req after ack is re-eligible from the next IDLE, subject to the round-robin pointer. This prevents starvation: every waiting requester is served within N_REQ frames.

Decomposition:
- Shared package tx_sched_pkg holds:
  - state encoding constants: IDLE=2'd0, LOAD=2'd1, SEND=2'd2, GAP=2'd3;
  - default parameter values;
  - the clog2 helper function.
- One sub-module, rr_pick (combinational):
  - inputs: req vector and ptr;
  - outputs: winner index and a valid flag.
- Pointer, counters and FSM stay in the top.

Test Plan:
- Single frame:
  - Stimulus: req[2]=1, req_data[2]=8'hA5; tx_done pulsed 9 cycles after tx_start rises.
  - Response: grant=4'b0100 at t+1; tx_data=8'hA5; tx_start high at t+2 until the tx_done cycle; ack[2] pulse; busy low after 2 GAP cycles.
- Contention:
  - Stimulus: req=4'b1011 held with data 8'h11/22/–/44; auto-done responder.
  - Response: grant order 0,1,3,0; each byte appears on tx_data in matching order.
- Fairness:
  - Stimulus: all four req held for 8 frames.
  - Response: cur_id sequence 0,1,2,3,0,1,2,3; no requester is granted twice before the others.
- Timeout:
  - Stimulus: req[1]=1; tx_done never asserted.
  - Response: after TIMEOUT+1 SEND cycles, err pulses once, ack stays 0, tx_start drops, and the scheduler returns to IDLE.
- Boundary:
  - Stimulus: tx_done asserted exactly when the counter==TIMEOUT.
  - Response: ack pulses, err stays 0.
- Reset mid-frame:
  - Stimulus: reset for 1 cycle during SEND.
  - Response: next cycle all outputs are at reset values, with no ack/err. With req still high, the next grant goes to index 0.
